// File: rtl/display_timing_gen.sv
// Raster timing generator for parallel-RGB LCD panels: pixel-clock divider, h/v counters, registered syncs, DE and coordinates.
// Optional fetch-ahead coordinates are enabled by defining DISPLAY_TIMING_PREFETCH_EN.
module display_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 320,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 64,
    parameter int H_BP     = 8,
    parameter int V_ACTIVE = 256,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int COORD_W  = 10,
    parameter int PREFETCH = 2
) (
    input  logic               in_main_clock,
    input  logic               in_reset,
    output logic               out_display_clock,
    output logic               out_display_hs,
    output logic               out_display_vs,
    output logic               out_display_de,
    output logic [COORD_W-1:0] out_coord_x,
    output logic [COORD_W-1:0] out_coord_y,
    output logic               out_line_start,
    output logic               out_frame_start
`ifdef DISPLAY_TIMING_PREFETCH_EN
    ,
    output logic [COORD_W-1:0] out_fetch_x,
    output logic [COORD_W-1:0] out_fetch_y,
    output logic               out_fetch_valid
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT_C  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_C  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
        $error("display_timing_gen: CLK_DIV must be even and >= 2");
    end
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_region
        $error("display_timing_gen: every active/porch/sync width must be >= 1");
    end
    if ((H_TOTAL - 1) >= (1 << COORD_W) || (V_TOTAL - 1) >= (1 << COORD_W)) begin : g_bad_coord
        $error("display_timing_gen: COORD_W too narrow for the raster totals");
    end

    logic [DIV_W-1:0]   div_cnt;
    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               tick;

    assign tick = (div_cnt == DIV_LAST);

    // Raster position: h and v only move on the last main clock of each pixel.
    always_ff @(posedge in_main_clock) begin
        if (in_reset) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                if (h_cnt == H_LAST) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end
        end
    end

    logic h_active, v_active, de_now, line_first;
    assign h_active   = (h_cnt < H_ACT_C);
    assign v_active   = (v_cnt < V_ACT_C);
    assign de_now     = h_active && v_active;
    assign line_first = (h_cnt == '0) && (div_cnt == '0);

    // Outputs describe the counter state registered on the previous clock.
    always_ff @(posedge in_main_clock) begin
        if (in_reset) begin
            out_display_clock <= 1'b0;
            out_display_hs    <= ~HS_POL;
            out_display_vs    <= ~VS_POL;
            out_display_de    <= 1'b0;
            out_coord_x       <= '0;
            out_coord_y       <= '0;
            out_line_start    <= 1'b0;
            out_frame_start   <= 1'b0;
        end else begin
            out_display_clock <= (div_cnt >= DIV_HALF);
            out_display_hs    <= (h_cnt >= HS_START && h_cnt < HS_END) ? HS_POL : ~HS_POL;
            out_display_vs    <= (v_cnt >= VS_START && v_cnt < VS_END) ? VS_POL : ~VS_POL;
            out_display_de    <= de_now;
            out_coord_x       <= de_now ? h_cnt : '0;
            out_coord_y       <= de_now ? v_cnt : '0;
            out_line_start    <= line_first;
            out_frame_start   <= line_first && (v_cnt == '0);
        end
    end

`ifdef DISPLAY_TIMING_PREFETCH_EN
    if (PREFETCH < 1 || PREFETCH > H_FP + H_SYNC + H_BP - 1) begin : g_bad_prefetch
        $error("display_timing_gen: PREFETCH out of range");
    end

    logic [COORD_W-1:0] fh_cnt;
    logic [COORD_W-1:0] fv_cnt;
    logic               f_active;

    // Shadow raster starting PREFETCH pixels ahead so the lead is exact from the first pixel.
    always_ff @(posedge in_main_clock) begin
        if (in_reset) begin
            fh_cnt <= COORD_W'(PREFETCH);
            fv_cnt <= '0;
        end else if (tick) begin
            if (fh_cnt == H_LAST) begin
                fh_cnt <= '0;
                fv_cnt <= (fv_cnt == V_LAST) ? '0 : fv_cnt + 1'b1;
            end else begin
                fh_cnt <= fh_cnt + 1'b1;
            end
        end
    end

    assign f_active = (fh_cnt < H_ACT_C) && (fv_cnt < V_ACT_C);

    always_ff @(posedge in_main_clock) begin
        if (in_reset) begin
            out_fetch_x     <= '0;
            out_fetch_y     <= '0;
            out_fetch_valid <= 1'b0;
        end else begin
            out_fetch_x     <= f_active ? fh_cnt : '0;
            out_fetch_y     <= f_active ? fv_cnt : '0;
            out_fetch_valid <= f_active;
        end
    end
`endif

endmodule

// File: tb/tb_display_timing_gen.sv
// Scoreboard bench for display_timing_gen on a small 14x8 raster; a stimulus process queues the expected
// output of every clock and a negedge monitor pops and compares, plus hand-computed tallies of the first frame.
module tb_display_timing_gen;

    localparam int CLK_DIV = 4;
    localparam int H_ACT = 8, H_FP = 2, H_SYN = 3, H_BP = 1;
    localparam int V_ACT = 4, V_FP = 1, V_SYN = 2, V_BP = 1;
    localparam int H_TOT = H_ACT + H_FP + H_SYN + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;
    localparam int CW = 10;
    localparam int PRE = 2;

    typedef struct packed {
        logic          dclk;
        logic          hs;
        logic          vs;
        logic          de;
        logic [CW-1:0] x;
        logic [CW-1:0] y;
        logic          ls;
        logic          fs;
`ifdef DISPLAY_TIMING_PREFETCH_EN
        logic [CW-1:0] fx;
        logic [CW-1:0] fy;
        logic          fv;
`endif
    } out_t;

    typedef struct {
        out_t val;
        bit   is_reset;
    } entry_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          dclk, hs, vs, de, ls, fs;
    logic [CW-1:0] cx, cy;
`ifdef DISPLAY_TIMING_PREFETCH_EN
    logic [CW-1:0] fx, fy;
    logic          fvalid;
`endif

    display_timing_gen #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYN), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYN), .V_BP(V_BP),
        .HS_POL(1'b0), .VS_POL(1'b0), .COORD_W(CW), .PREFETCH(PRE)
    ) dut (
        .in_main_clock(clock),
        .in_reset(reset),
        .out_display_clock(dclk),
        .out_display_hs(hs),
        .out_display_vs(vs),
        .out_display_de(de),
        .out_coord_x(cx),
        .out_coord_y(cy),
        .out_line_start(ls),
        .out_frame_start(fs)
`ifdef DISPLAY_TIMING_PREFETCH_EN
        ,
        .out_fetch_x(fx),
        .out_fetch_y(fy),
        .out_fetch_valid(fvalid)
`endif
    );

    always #5 clock = ~clock;

    entry_t exp_q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     t_model = 0;

    // Reference raster: derived from the clock index since reset release by division, not by counters.
    function automatic out_t model(input int t);
        out_t o;
        int   dv, p, h, v;
        int   pf, hf, vf;
        dv = t % CLK_DIV;
        p  = t / CLK_DIV;
        h  = p % H_TOT;
        v  = (p / H_TOT) % V_TOT;
        o.dclk = (dv >= CLK_DIV / 2);
        o.hs   = !(h >= H_ACT + H_FP && h < H_ACT + H_FP + H_SYN);
        o.vs   = !(v >= V_ACT + V_FP && v < V_ACT + V_FP + V_SYN);
        o.de   = (h < H_ACT) && (v < V_ACT);
        o.x    = o.de ? CW'(h) : '0;
        o.y    = o.de ? CW'(v) : '0;
        o.ls   = (h == 0) && (dv == 0);
        o.fs   = o.ls && (v == 0);
`ifdef DISPLAY_TIMING_PREFETCH_EN
        pf = (t + PRE * CLK_DIV) / CLK_DIV;
        hf = pf % H_TOT;
        vf = (pf / H_TOT) % V_TOT;
        o.fv = (hf < H_ACT) && (vf < V_ACT);
        o.fx = o.fv ? CW'(hf) : '0;
        o.fy = o.fv ? CW'(vf) : '0;
`else
        pf = 0; hf = 0; vf = 0;
`endif
        return o;
    endfunction

    function automatic out_t reset_vec();
        out_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    // Drive n clocks with the given reset level, queueing the output expected after each edge.
    task automatic applyStimulus(input bit rst, input int n);
        entry_t e;
        for (int i = 0; i < n; i++) begin
            reset = rst;
            e.is_reset = rst;
            if (rst) begin
                e.val   = reset_vec();
                t_model = 0;
            end else begin
                e.val   = model(t_model);
                t_model = t_model + 1;
            end
            exp_q.push_back(e);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    int mon_cycle = 0, seg = 0;
    bit was_reset = 1'b1;
    int fs_pos[$];
    int ls_count = 0, de_line0 = 0, de_frame = 0, hs_low = 0, vs_low = 0;
    int hs_first = -1, vs_first = -1;

    // Monitor: pops one expected record per clock and tallies first-segment timing features.
    always @(negedge clock) begin
        entry_t e;
        out_t   act;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
`ifdef DISPLAY_TIMING_PREFETCH_EN
            act = {dclk, hs, vs, de, cx, cy, ls, fs, fx, fy, fvalid};
`else
            act = {dclk, hs, vs, de, cx, cy, ls, fs};
`endif
            n_checks++;
            if (act !== e.val) begin
                n_fail++;
                $display("[TB] FAIL cycle seg%0d clk%0d: got %h, expected %h", seg, mon_cycle + 1, act, e.val);
            end
            if (e.is_reset) begin
                mon_cycle = 0;
                was_reset = 1'b1;
            end else begin
                if (was_reset) seg++;
                was_reset = 1'b0;
                mon_cycle++;
                if (seg == 1) begin
                    if (fs === 1'b1) fs_pos.push_back(mon_cycle);
                    if (ls === 1'b1) ls_count++;
                    if (mon_cycle <= 56 && de === 1'b1) de_line0++;
                    if (mon_cycle <= 448) begin
                        if (de === 1'b1) de_frame++;
                        if (hs === 1'b0) hs_low++;
                        if (vs === 1'b0) vs_low++;
                        if (hs === 1'b0 && hs_first < 0) hs_first = mon_cycle;
                        if (vs === 1'b0 && vs_first < 0) vs_first = mon_cycle;
                    end
                end
            end
        end
    end

    initial begin
        int guard;
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 1000);
        applyStimulus(1'b1, 2);
        applyStimulus(1'b0, 132);
        applyStimulus(1'b1, 1);
        applyStimulus(1'b0, 500);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clock);
            guard++;
        end
        checkOutput("scoreboard_drained", exp_q.size(), 0);

        checkOutput("frame_start_count", fs_pos.size(), 3);
        checkOutput("frame_start_0", (fs_pos.size() > 0) ? fs_pos[0] : -1, 1);
        checkOutput("frame_start_1", (fs_pos.size() > 1) ? fs_pos[1] : -1, 449);
        checkOutput("frame_start_2", (fs_pos.size() > 2) ? fs_pos[2] : -1, 897);
        checkOutput("line_start_count", ls_count, 18);
        checkOutput("de_clocks_line0", de_line0, 32);
        checkOutput("de_clocks_frame", de_frame, 128);
        checkOutput("hs_first_low", hs_first, 41);
        checkOutput("hs_low_clocks_frame", hs_low, 96);
        checkOutput("vs_first_low", vs_first, 281);
        checkOutput("vs_low_clocks_frame", vs_low, 112);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
